// File: rtl/ex_mdu.sv
// EX stage: single-cycle logic/shift results plus a 32-step restoring divider writing HI/LO.
// Latency: logic/shift 0 cycles; divide 33 stall cycles then a one-cycle DONE write (div-by-zero: 1 + 1).
module ex_mdu (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [2:0]  alusel_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic        annul_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stallreq_o
);
   localparam int DIV_STEPS = 32;

   localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

   localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
   localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
   localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
   localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
   localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
   localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
   localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] quot, rem, dvsr;
   logic [4:0]  cnt;
   logic        neg_q, neg_r;
   logic        is_div, is_signed, start, stall, whilo;
   logic [32:0] rem_sh, trial;
   logic [31:0] abs_a, abs_b, logic_res, shift_res;

   assign is_div    = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
   assign is_signed = (aluop_i == EXE_DIV_OP);
   assign abs_a     = (is_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
   assign abs_b     = (is_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
   assign start     = (state == IDLE) && is_div && !annul_i;

   // One restoring step: bring in the next dividend bit, try subtracting the divisor.
   assign rem_sh = {rem, quot[31]};
   assign trial  = rem_sh - {1'b0, dvsr};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      whilo     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               stall     = 1'b1;
               state_nxt = (reg2_i == 32'd0) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (annul_i) begin
               state_nxt = IDLE;
            end else begin
               stall = 1'b1;
               if (cnt == 5'(DIV_STEPS - 1)) state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            whilo     = !annul_i;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quot  <= '0;
         rem   <= '0;
         dvsr  <= '0;
         cnt   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (start) begin
         // A zero divisor leaves quotient/remainder at 0 and skips the fixup.
         quot  <= (reg2_i == 32'd0) ? 32'd0 : abs_a;
         rem   <= '0;
         dvsr  <= abs_b;
         cnt   <= '0;
         neg_q <= (reg2_i != 32'd0) && is_signed && (reg1_i[31] ^ reg2_i[31]);
         neg_r <= (reg2_i != 32'd0) && is_signed && reg1_i[31];
      end else if (state == BUSY) begin
         quot <= {quot[30:0], ~trial[32]};
         rem  <= trial[32] ? rem_sh[31:0] : trial[31:0];
         cnt  <= cnt + 5'd1;
      end
   end

   always_comb begin
      logic_res = '0;
      case (aluop_i)
         EXE_OR_OP:  logic_res = reg1_i | reg2_i;
         EXE_AND_OP: logic_res = reg1_i & reg2_i;
         EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
         EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
         default:    logic_res = '0;
      endcase
   end

   always_comb begin
      shift_res = '0;
      case (aluop_i)
         EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
         EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
         EXE_SRA_OP: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
         default:    shift_res = '0;
      endcase
   end

   always_comb begin
      wd_o       = rst ? 5'd0 : wd_i;
      wreg_o     = rst ? 1'b0 : wreg_i;
      wdata_o    = '0;
      if (!rst) begin
         case (alusel_i)
            EXE_RES_LOGIC: wdata_o = logic_res;
            EXE_RES_SHIFT: wdata_o = shift_res;
            default:       wdata_o = '0;
         endcase
      end
      stallreq_o = stall && !rst;
      whilo_o    = whilo && !rst;
      lo_o       = whilo_o ? (neg_q ? (~quot + 32'd1) : quot) : 32'd0;
      hi_o       = whilo_o ? (neg_r ? (~rem + 32'd1) : rem) : 32'd0;
   end
endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: random logic/shift and divide vectors against an arithmetic reference model.
module tb_ex_mdu;
   localparam logic [2:0] RES_NOP   = 3'b000;
   localparam logic [2:0] RES_LOGIC = 3'b001;
   localparam logic [2:0] RES_SHIFT = 3'b010;
   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_AND  = 8'b0010_0100;
   localparam logic [7:0] OP_OR   = 8'b0010_0101;
   localparam logic [7:0] OP_XOR  = 8'b0010_0110;
   localparam logic [7:0] OP_NOR  = 8'b0010_0111;
   localparam logic [7:0] OP_SLL  = 8'b0111_1100;
   localparam logic [7:0] OP_SRL  = 8'b0000_0010;
   localparam logic [7:0] OP_SRA  = 8'b0000_0011;
   localparam logic [7:0] OP_DIV  = 8'b0001_1010;
   localparam logic [7:0] OP_DIVU = 8'b0001_1011;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop;
   logic [2:0]  alusel;
   logic [31:0] reg1, reg2;
   logic [4:0]  wd;
   logic        wreg, annul;
   logic [4:0]  wd_o;
   logic        wreg_o, whilo_o, stallreq_o;
   logic [31:0] wdata_o, hi_o, lo_o;

   int nvec = 0;
   int nerr = 0;

   ex_mdu dut (
      .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
      .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .annul_i(annul),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
      .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] alu_model(input logic [2:0] sel, input logic [7:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
      int unsigned n;
      logic [31:0] fill;
      n = a % 32;
      fill = (b[31] && n != 0) ? ~(32'hFFFF_FFFF >> n) : 32'd0;
      if (sel == RES_LOGIC) begin
         if (op == OP_OR)  return a | b;
         if (op == OP_AND) return a & b;
         if (op == OP_XOR) return a ^ b;
         if (op == OP_NOR) return ~(a | b);
      end else if (sel == RES_SHIFT) begin
         if (op == OP_SLL) return b << n;
         if (op == OP_SRL) return b >> n;
         if (op == OP_SRA) return (b >> n) | fill;
      end
      return 32'd0;
   endfunction

   task automatic div_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] q, output logic [31:0] r);
      longint sa, sb, lq, lr;
      if (b == 0) begin
         q = 0; r = 0;
      end else if (op == OP_DIVU) begin
         q = a / b; r = a % b;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         lq = sa / sb;
         lr = sa % sb;
         q = lq[31:0];
         r = lr[31:0];
      end
   endtask

   task automatic do_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      logic [31:0] eq, er;
      int ncyc;
      div_model(op, a, b, eq, er);
      @(posedge clk); #1;
      aluop = op; alusel = RES_NOP; reg1 = a; reg2 = b; annul = 1'b0;
      ncyc = 0;
      @(negedge clk);
      while (stallreq_o && ncyc < 100) begin
         ncyc++;
         @(negedge clk);
      end
      check({tag, ".stall_cycles"}, ncyc, (b == 0) ? 32'd1 : 32'd33);
      check({tag, ".whilo"}, 32'(whilo_o), 32'd1);
      check({tag, ".lo"}, lo_o, eq);
      check({tag, ".hi"}, hi_o, er);
      check({tag, ".wdata"}, wdata_o, 32'd0);
      aluop = OP_NOP;
      @(negedge clk);
      check({tag, ".whilo_after"}, 32'(whilo_o), 32'd0);
      check({tag, ".stall_after"}, 32'(stallreq_o), 32'd0);
   endtask

   initial begin
      logic [2:0]  sel;
      logic [7:0]  op;
      logic [7:0]  ops [9];
      int          whilo_seen;

      ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, 8'hEE, OP_NOP};
      rst = 1'b1; aluop = OP_DIV; alusel = RES_LOGIC; reg1 = 32'h1234_5678;
      reg2 = 32'h0000_0003; wd = 5'd17; wreg = 1'b1; annul = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.wd", 32'(wd_o), 32'd0);
      check("rst.wreg", 32'(wreg_o), 32'd0);
      check("rst.wdata", wdata_o, 32'd0);
      check("rst.stall", 32'(stallreq_o), 32'd0);
      check("rst.whilo", 32'(whilo_o), 32'd0);
      check("rst.hi", hi_o, 32'd0);
      check("rst.lo", lo_o, 32'd0);
      aluop = OP_NOP;
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed logic/shift vectors.
      alusel = RES_LOGIC; aluop = OP_OR; reg1 = 32'h0000_F0F0; reg2 = 32'h0000_0F0F;
      wd = 5'd3; wreg = 1'b1;
      #2;
      check("ori.wdata", wdata_o, 32'h0000_FFFF);
      check("ori.wreg", 32'(wreg_o), 32'd1);
      check("ori.wd", 32'(wd_o), 32'd3);
      check("ori.stall", 32'(stallreq_o), 32'd0);
      alusel = RES_SHIFT; aluop = OP_SRA; reg1 = 32'd4; reg2 = 32'h8000_0000;
      #2;
      check("sra", wdata_o, 32'hF800_0000);
      aluop = OP_SRL;
      #2;
      check("srl", wdata_o, 32'h0800_0000);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0:       sel = RES_LOGIC;
            1:       sel = RES_SHIFT;
            2:       sel = RES_NOP;
            default: sel = 3'($urandom_range(3, 7));
         endcase
         op = ops[$urandom_range(0, 8)];
         alusel = sel; aluop = op; reg1 = $urandom; reg2 = $urandom;
         wd = 5'($urandom); wreg = 1'($urandom);
         @(negedge clk);
         check("rnd.wdata", wdata_o, alu_model(sel, op, reg1, reg2));
         check("rnd.wd", 32'(wd_o), 32'(wd));
         check("rnd.wreg", 32'(wreg_o), 32'(wreg));
         check("rnd.stall", 32'(stallreq_o), 32'd0);
      end
      aluop = OP_NOP; alusel = RES_NOP;

      do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7);
      do_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
      do_div("div_7_0", OP_DIV, 32'd7, 32'd0);
      do_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      do_div("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 20));
            2:       b = -32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         do_div("rnd_div", ($urandom_range(0, 1) != 0) ? OP_DIV : OP_DIVU, a, b);
      end

      // Annul during BUSY step 10.
      @(posedge clk); #1;
      aluop = OP_DIVU; reg1 = 32'd1000; reg2 = 32'd3;
      repeat (11) @(posedge clk);
      #1;
      annul = 1'b1; aluop = OP_NOP;
      #1;
      check("annul.stall", 32'(stallreq_o), 32'd0);
      check("annul.whilo", 32'(whilo_o), 32'd0);
      @(posedge clk); #1;
      annul = 1'b0;
      whilo_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         whilo_seen += int'(whilo_o) + int'(stallreq_o);
      end
      check("annul.no_write", 32'(whilo_seen), 32'd0);
      // Annul in IDLE must not start a divide.
      @(posedge clk); #1;
      aluop = OP_DIVU; annul = 1'b1;
      #1;
      check("annul_idle.stall", 32'(stallreq_o), 32'd0);
      @(posedge clk); #1;
      aluop = OP_NOP; annul = 1'b0;
      @(negedge clk);
      check("annul_idle.idle", 32'(stallreq_o), 32'd0);
      do_div("divu_9_3", OP_DIVU, 32'd9, 32'd3);

      // Reset mid-BUSY.
      @(posedge clk); #1;
      aluop = OP_DIV; reg1 = 32'd12345; reg2 = 32'd17; alusel = RES_LOGIC; wd = 5'd9; wreg = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rstbusy.stall", 32'(stallreq_o), 32'd0);
      check("rstbusy.whilo", 32'(whilo_o), 32'd0);
      check("rstbusy.wd", 32'(wd_o), 32'd0);
      check("rstbusy.wreg", 32'(wreg_o), 32'd0);
      check("rstbusy.wdata", wdata_o, 32'd0);
      aluop = OP_NOP; alusel = RES_NOP;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstbusy.idle", 32'(stallreq_o), 32'd0);
      do_div("after_rst", OP_DIV, 32'hFFFF_FF00, 32'd7);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
